ram_req_bridge: RTL

- Initiator-side controller that drives the team's 1-read/1-write synchronous word RAM: 32-bit data, registered read port, read-first, no byte enables.
- Converts a valid/ready request channel into RAM port activity, absorbing the RAM's one-cycle read latency.
- Implements byte-strobed writes as read-modify-write.
- Returns exactly one response per request on a valid/ready response channel; sits between the core's load/store unit and the RAM.

---
 rtl/ram_req_bridge.sv | 100 ++++++++++
 1 files changed

// File: rtl/ram_req_bridge.sv
// ram_req_bridge: valid/ready request channel to a 1R1W synchronous word RAM bridge.
//
// Ports:
//   clk, rst_n           clock (rising edge) and asynchronous active-low reset
//   i_req_*/o_req_ready  request channel: valid, wen, byte addr, wdata, wstrb
//   o_resp_*/i_resp_ready response channel: valid, rdata (0 for writes), err
//   i_ram_q              RAM registered read data (one-cycle latency, read-first)
//   o_ram_d, o_ram_wen   RAM write data / write enable
//   o_ram_*_address      RAM word addresses (write address always equals read address)
//
// Build option: define RAM_BRIDGE_RANGE_CHK_EN to reject out-of-range or misaligned
// requests with resp_err=1; otherwise addresses wrap and resp_err is always 0.
module ram_req_bridge #(
   parameter int          AW        = 10,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_req_valid,
   output logic          o_req_ready,
   input  logic          i_req_wen,
   input  logic [31:0]   i_req_addr,
   input  logic [31:0]   i_req_wdata,
   input  logic [3:0]    i_req_wstrb,
   output logic          o_resp_valid,
   input  logic          i_resp_ready,
   output logic [31:0]   o_resp_rdata,
   output logic          o_resp_err,
   input  logic [31:0]   i_ram_q,
   output logic [31:0]   o_ram_d,
   output logic [AW-1:0] o_ram_write_address,
   output logic [AW-1:0] o_ram_read_address,
   output logic          o_ram_wen
);
   typedef enum logic [1:0] {IDLE, READ, RMW, RESP} state_t;
   state_t        r_state, w_next;
   logic [31:0]   w_off, w_merge;
   logic [AW-1:0] w_idx;
   logic          w_err, w_acc, w_full, w_part, w_unused;
   logic [AW-1:0] r_idx;
   logic [31:0]   r_wdata, r_rdata;
   logic [3:0]    r_wstrb;
   logic          r_err;
   assign w_off    = i_req_addr - BASE_ADDR;
   assign w_idx    = w_off[AW+1:2];
   assign w_unused = ^{w_off[31:AW+2], w_off[1:0]};
`ifdef RAM_BRIDGE_RANGE_CHK_EN
   assign w_err = (i_req_addr < BASE_ADDR) || (w_off[31:AW+2] != '0) || (i_req_addr[1:0] != 2'b00);
`else
   assign w_err = 1'b0;
`endif
   assign w_acc  = i_req_valid && (r_state == IDLE);
   assign w_full = i_req_wen && (i_req_wstrb == 4'hF);
   assign w_part = i_req_wen && (i_req_wstrb != 4'hF) && (i_req_wstrb != 4'h0);
   // RMW merge: strobed bytes from the latched write data, the rest from the old word
   for (genvar b = 0; b < 4; b++) begin : g_merge
      assign w_merge[8*b +: 8] = r_wstrb[b] ? r_wdata[8*b +: 8] : i_ram_q[8*b +: 8];
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:      if (w_acc) w_next = w_err ? RESP : !i_req_wen ? READ : w_part ? RMW : RESP;
         READ, RMW: w_next = RESP;
         RESP:      if (i_resp_ready) w_next = IDLE;
         default:   w_next = IDLE;
      endcase
   end
   // Gating with rst_n makes the write enable drop the moment reset asserts
   always_comb begin
      o_req_ready         = r_state == IDLE;
      o_resp_valid        = r_state == RESP;
      o_ram_read_address  = (r_state == IDLE) ? w_idx : r_idx;
      o_ram_write_address = (r_state == IDLE) ? w_idx : r_idx;
      o_ram_d             = (r_state == IDLE) ? i_req_wdata : w_merge;
      o_ram_wen           = rst_n && ((w_acc && w_full && !w_err) || (r_state == RMW));
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx   <= '0;
         r_wdata <= '0;
         r_wstrb <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else if (w_acc) begin
         r_idx   <= w_idx;
         r_wdata <= i_req_wdata;
         r_wstrb <= i_req_wstrb;
         r_rdata <= '0;
         r_err   <= w_err;
      end else if (r_state == READ) begin
         r_rdata <= i_ram_q;
      end
   end
   assign o_resp_rdata = r_rdata;
   assign o_resp_err   = r_err;
endmodule
